// File: rtl/ml_qspi_master.sv
// Quad-SPI host engine toward the MARLANN accelerator: one byte per handshake,
// shifted as two nibbles in SPI mode 0, with chip-select framing and irq/err sync.
`timescale 1ns/1ps
module ml_qspi_master #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_read,
  input  logic       cmd_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ml_clk,
  output logic       ml_csb,
  output logic [3:0] io_do,
  output logic [3:0] io_oe,
  input  logic [3:0] io_di,
  input  logic       ml_irq,
  input  logic       ml_err,
  input  logic       err_clear,
  output logic       irq,
  output logic       err_flag
);

  localparam logic [7:0] HM1 = 8'(CLKDIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_END} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ph_q, ph_d;
  logic       sclk_q, sclk_d;
  logic       csb_q, csb_d;
  logic [3:0] oe_q, oe_d;
  logic [3:0] do_q, do_d;
  logic       rv_q, rv_d;
  logic [7:0] rd_q, rd_d;
  logic       errf_q, errf_d;
  logic       irq_s1_q, irq_s2_q, err_s1_q, err_s2_q;

  logic [3:0] lo_q;
  logic       read_q, last_q;

  logic accept, wrap;

  assign cmd_ready = resetn && (state_q == S_IDLE || state_q == S_WAIT);
  assign accept    = cmd_valid && cmd_ready;
  assign wrap      = (cnt_q == 8'd0);

  assign busy      = (state_q != S_IDLE);
  assign ml_clk    = sclk_q;
  assign ml_csb    = csb_q;
  assign io_oe     = oe_q;
  assign io_do     = do_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign irq       = irq_s2_q;
  assign err_flag  = errf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    sclk_d  = sclk_q;
    csb_d   = csb_q;
    oe_d    = oe_q;
    do_d    = do_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    errf_d  = err_s2_q ? 1'b1 : (err_clear ? 1'b0 : errf_q);

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = HM1;
          ph_d    = 2'd0;
          csb_d   = 1'b0;
          sclk_d  = 1'b0;
          // Turnaround lands the cycle after accept; first rise is still H cycles away.
          if (cmd_read) begin
            oe_d = 4'h0;
            do_d = 4'h0;
          end else begin
            oe_d = 4'hF;
            do_d = cmd_data[7:4];
          end
        end
      end
      S_SHIFT: begin
        if (wrap) begin
          cnt_d = HM1;
          ph_d  = 2'(ph_q + 2'd1);
          case (ph_q)
            2'd0: sclk_d = 1'b1;
            2'd1: begin
              sclk_d = 1'b0;
              if (read_q) rd_d[7:4] = io_di;
              else        do_d      = lo_q;
            end
            2'd2: sclk_d = 1'b1;
            default: begin
              sclk_d  = 1'b0;
              ph_d    = 2'd0;
              state_d = last_q ? S_END : S_WAIT;
              if (read_q) begin
                rd_d[3:0] = io_di;
                rv_d      = 1'b1;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        // Two half-periods: release csb after the first, return to idle after the second.
        oe_d = 4'h0;
        if (wrap) begin
          cnt_d = HM1;
          if (ph_q == 2'd0) begin
            csb_d = 1'b1;
            ph_d  = 2'd1;
          end else begin
            state_d = S_IDLE;
            ph_d    = 2'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ph_q     <= 2'd0;
      sclk_q   <= 1'b0;
      csb_q    <= 1'b1;
      oe_q     <= 4'h0;
      do_q     <= 4'h0;
      rv_q     <= 1'b0;
      rd_q     <= 8'd0;
      errf_q   <= 1'b0;
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
      err_s1_q <= 1'b0;
      err_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      sclk_q   <= sclk_d;
      csb_q    <= csb_d;
      oe_q     <= oe_d;
      do_q     <= do_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
      errf_q   <= errf_d;
      irq_s1_q <= ml_irq;
      irq_s2_q <= irq_s1_q;
      err_s1_q <= ml_err;
      err_s2_q <= err_s1_q;
    end
  end

  // Command fields are plain data captured on accept; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q   <= cmd_data[3:0];
      read_q <= cmd_read;
      last_q <= cmd_last;
    end
  end

endmodule
